// File: rtl/dmem_pkg.sv
// Shared definitions for the MEM-stage store buffer: default geometry and
// the buffered-store entry layout.
package dmem_pkg;

   localparam int SB_ADDR_W = 9;
   localparam int SB_DATA_W = 32;
   localparam int SB_DEPTH  = 4;
   localparam int SB_PTR_W  = $clog2(SB_DEPTH);
   localparam int SB_CNT_W  = SB_PTR_W + 1;

   typedef struct packed {
      logic                 valid;
      logic [SB_ADDR_W-1:0] addr;
      logic [SB_DATA_W-1:0] data;
   } sb_entry_t;

endpackage

// File: rtl/sb_fwd_match.sv
// Youngest-match finder: scans buffered stores from oldest to youngest so the
// last hit seen is the youngest store to ld_addr.
module sb_fwd_match
   import dmem_pkg::*;
#(
   parameter int DEPTH = SB_DEPTH,
   parameter int PTR_W = $clog2(DEPTH),
   parameter int CNT_W = PTR_W + 1
) (
   input  sb_entry_t              entries [DEPTH],
   input  logic [PTR_W-1:0]       head,
   input  logic [CNT_W-1:0]       count,
   input  logic [SB_ADDR_W-1:0]   ld_addr,
   output logic                   hit,
   output logic [SB_DATA_W-1:0]   data
);

   logic [DEPTH-1:0] match;
   logic [PTR_W-1:0] idx [DEPTH];

   // Slot gi holds the store of age gi (0 = oldest); pointer wrap is free
   // because DEPTH is a power of two.
   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_age
      assign idx[gi]   = head + PTR_W'(gi);
      assign match[gi] = (CNT_W'(gi) < count) && entries[idx[gi]].valid
                         && (entries[idx[gi]].addr == ld_addr);
   end

   always_comb begin
      hit  = 1'b0;
      data = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (match[i]) begin
            hit  = 1'b1;
            data = entries[idx[i]].data;
         end
      end
   end

endmodule

// File: rtl/dmem_store_buffer.sv
// In-order store buffer in front of the data cache: queues stores, drains one
// per granted cycle into the cache write port, forwards buffered data to loads.
module dmem_store_buffer
   import dmem_pkg::*;
#(
   parameter int ADDR_W = SB_ADDR_W,
   parameter int DATA_W = SB_DATA_W,
   parameter int DEPTH  = SB_DEPTH
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       st_valid,
   input  logic [ADDR_W-1:0]          st_addr,
   input  logic [DATA_W-1:0]          st_data,
   output logic                       st_ready,
   input  logic [ADDR_W-1:0]          ld_addr,
   output logic [DATA_W-1:0]          ld_data,
   output logic [ADDR_W-1:0]          dc_raddr,
   input  logic [DATA_W-1:0]          dc_rdata,
   output logic [ADDR_W-1:0]          dc_waddr,
   output logic [DATA_W-1:0]          dc_wdata,
   output logic                       dc_we,
   input  logic                       wr_grant,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   sb_entry_t          entries_reg [DEPTH];
   logic [PTR_W-1:0]   head_reg, head_next;
   logic [PTR_W-1:0]   tail_reg, tail_next;
   logic [CNT_W-1:0]   count_reg, count_next;
   logic               push, pop;
   logic               fwd_hit;
   logic [DATA_W-1:0]  fwd_data;
   sb_entry_t          wr_entry;

   // A full buffer rejects stores even when the head drains this cycle.
   assign st_ready = (count_reg != CNT_W'(DEPTH)) && !reset;
   assign dc_we    = (count_reg != '0) && wr_grant && !reset;
   assign push     = st_valid && st_ready;
   assign pop      = dc_we;

   assign wr_entry = '{valid: 1'b1, addr: st_addr, data: st_data};

   always_comb begin
      head_next  = head_reg;
      tail_next  = tail_reg;
      count_next = count_reg;
      if (push) tail_next = tail_reg + 1'b1;
      if (pop)  head_next = head_reg + 1'b1;
      case ({push, pop})
         2'b10:   count_next = count_reg + 1'b1;
         2'b01:   count_next = count_reg - 1'b1;
         default: count_next = count_reg;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         head_reg  <= '0;
         tail_reg  <= '0;
         count_reg <= '0;
      end else begin
         head_reg  <= head_next;
         tail_reg  <= tail_next;
         count_reg <= count_next;
      end
   end

   // Push and pop never target the same slot: that needs count 0 or DEPTH.
   always_ff @(posedge clk) begin
      for (int i = 0; i < DEPTH; i++) begin
         if (reset)
            entries_reg[i].valid <= 1'b0;
         else if (push && (tail_reg == PTR_W'(i)))
            entries_reg[i] <= wr_entry;
         else if (pop && (head_reg == PTR_W'(i)))
            entries_reg[i].valid <= 1'b0;
      end
   end

   sb_fwd_match #(
      .DEPTH (DEPTH),
      .PTR_W (PTR_W),
      .CNT_W (CNT_W)
   ) u_fwd (
      .entries (entries_reg),
      .head    (head_reg),
      .count   (count_reg),
      .ld_addr (ld_addr),
      .hit     (fwd_hit),
      .data    (fwd_data)
   );

   assign dc_raddr = ld_addr;
   assign ld_data  = fwd_hit ? fwd_data : dc_rdata;
   assign dc_waddr = entries_reg[head_reg].addr;
   assign dc_wdata = entries_reg[head_reg].data;
   assign empty    = (count_reg == '0);
   assign count    = count_reg;

endmodule

// File: tb/tb_dmem_store_buffer.sv
// Bench for dmem_store_buffer: directed scenarios then random traffic, checked
// each cycle against a queue-based model and a behavioural cache memory.
module tb_dmem_store_buffer;

   localparam int AW = 9;
   localparam int DW = 32;
   localparam int DP = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          st_valid;
   logic [AW-1:0] st_addr;
   logic [DW-1:0] st_data;
   logic          st_ready;
   logic [AW-1:0] ld_addr;
   logic [DW-1:0] ld_data;
   logic [AW-1:0] dc_raddr;
   logic [DW-1:0] dc_rdata;
   logic [AW-1:0] dc_waddr;
   logic [DW-1:0] dc_wdata;
   logic          dc_we;
   logic          wr_grant;
   logic          empty;
   logic [2:0]    count;

   always #5 clk = ~clk;

   dmem_store_buffer dut (
      .clk      (clk),
      .reset    (reset),
      .st_valid (st_valid),
      .st_addr  (st_addr),
      .st_data  (st_data),
      .st_ready (st_ready),
      .ld_addr  (ld_addr),
      .ld_data  (ld_data),
      .dc_raddr (dc_raddr),
      .dc_rdata (dc_rdata),
      .dc_waddr (dc_waddr),
      .dc_wdata (dc_wdata),
      .dc_we    (dc_we),
      .wr_grant (wr_grant),
      .empty    (empty),
      .count    (count)
   );

   // Behavioural cache: combinational read, write on clock edge.
   logic [DW-1:0] cache_mem [512];
   bit            cache_init = 1'b0;
   assign dc_rdata = cache_mem[dc_raddr];
   always @(posedge clk) begin
      if (!cache_init) begin
         for (int i = 0; i < 512; i++) cache_mem[i] <= 32'hC0DE0000 | i;
         cache_init <= 1'b1;
      end else if (dc_we) begin
         cache_mem[dc_waddr] <= dc_wdata;
      end
   end

   // Reference model: program-order store queue plus expected memory image.
   typedef struct packed {
      logic [AW-1:0] a;
      logic [DW-1:0] d;
   } st_t;
   st_t           q [$];
   logic [DW-1:0] ref_mem [512];

   int n_pass  = 0;
   int n_total = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic cycle(input logic rst_i, input logic sv, input logic [AW-1:0] sa,
                        input logic [DW-1:0] sd, input logic g, input logic [AW-1:0] la,
                        input bit chk);
      bit            exp_ready, exp_we, found;
      logic [DW-1:0] exp_ld;
      @(negedge clk);
      reset = rst_i; st_valid = sv; st_addr = sa; st_data = sd;
      wr_grant = g; ld_addr = la;
      #1;
      exp_ready = !rst_i && (q.size() < DP);
      exp_we    = !rst_i && (q.size() > 0) && g;
      found  = 1'b0;
      exp_ld = ref_mem[la];
      for (int i = q.size() - 1; i >= 0 && !found; i--) begin
         if (q[i].a == la) begin
            found  = 1'b1;
            exp_ld = q[i].d;
         end
      end
      if (chk) begin
         check("st_ready", 64'(st_ready), 64'(exp_ready));
         check("dc_we",    64'(dc_we),    64'(exp_we));
         check("count",    64'(count),    64'(q.size()));
         check("empty",    64'(empty),    64'(q.size() == 0));
         check("dc_raddr", 64'(dc_raddr), 64'(la));
         check("ld_data",  64'(ld_data),  64'(exp_ld));
         if (exp_we) begin
            check("dc_waddr", 64'(dc_waddr), 64'(q[0].a));
            check("dc_wdata", 64'(dc_wdata), 64'(q[0].d));
         end
      end
      @(posedge clk);
      if (rst_i) begin
         q.delete();
      end else begin
         if (exp_we) begin
            ref_mem[q[0].a] = q[0].d;
            void'(q.pop_front());
         end
         if (sv && exp_ready) q.push_back('{a: sa, d: sd});
      end
   endtask

   initial begin
      for (int i = 0; i < 512; i++) ref_mem[i] = 32'hC0DE0000 | i;
      reset = 1'b1; st_valid = 1'b0; st_addr = '0; st_data = '0;
      wr_grant = 1'b0; ld_addr = '0;

      cycle(1, 0, 0, 0, 0, 0, 0);
      cycle(1, 0, 0, 0, 1, 0, 1);
      cycle(0, 0, 0, 0, 0, 9'h010, 1);

      // single store, granted drain, then load from cache
      cycle(0, 1, 9'h010, 32'hDEADBEEF, 1, 9'h010, 1);
      cycle(0, 0, 0, 0, 1, 9'h010, 1);
      cycle(0, 0, 0, 0, 1, 9'h010, 1);

      // fill with grant low, fifth rejected, drain in order
      for (int i = 1; i <= 5; i++) cycle(0, 1, 9'(i), 32'h100 + i, 0, 9'(i), 1);
      for (int i = 0; i < 5; i++) cycle(0, 0, 0, 0, 1, 9'(i + 1), 1);

      // duplicate address forwarding
      cycle(0, 1, 9'h020, 32'd1, 0, 9'h020, 1);
      cycle(0, 1, 9'h020, 32'd2, 0, 9'h020, 1);
      cycle(0, 0, 0, 0, 0, 9'h020, 1);
      cycle(0, 0, 0, 0, 0, 9'h021, 1);
      cycle(0, 0, 0, 0, 1, 9'h020, 1);
      cycle(0, 0, 0, 0, 1, 9'h020, 1);
      cycle(0, 0, 0, 0, 0, 9'h020, 1);

      // full with drain: rejected, then accepted with simultaneous pop
      for (int i = 0; i < 4; i++) cycle(0, 1, 9'h030 + 9'(i), 32'h300 + i, 0, 9'h030, 1);
      cycle(0, 1, 9'h040, 32'h4444, 1, 9'h040, 1);
      cycle(0, 1, 9'h040, 32'h4444, 1, 9'h040, 1);
      cycle(0, 1, 9'h041, 32'h4545, 1, 9'h041, 1);
      for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 1, 9'h040, 1);

      // three buffered stores discarded by reset
      for (int i = 0; i < 3; i++) cycle(0, 1, 9'h050, 32'h500 + i, 0, 9'h050, 1);
      cycle(1, 1, 9'h051, 32'h5151, 1, 9'h050, 1);
      cycle(1, 0, 0, 0, 1, 9'h050, 1);
      cycle(0, 0, 0, 0, 1, 9'h050, 1);
      cycle(0, 0, 0, 0, 1, 9'h051, 1);

      // random traffic over a small address window to provoke hits
      for (int n = 0; n < 600; n++) begin
         cycle(($urandom_range(0, 59) == 0), $urandom_range(0, 1) == 1,
               9'($urandom_range(0, 7)), $urandom, $urandom_range(0, 2) != 0,
               9'($urandom_range(0, 7)), 1);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
